// File: rtl/sme_feeder_if.sv
// ----------------------------------------------------------------------------
// sme_feeder_if
// Host-side bundle of the string-matching feeder.
//   Byte channel (host -> feeder, valid/ready):
//     in_valid, in_ready, in_data[7:0], in_kind (0 string / 1 pattern), in_last
//   Result channel (feeder -> host, 1-cycle strobe):
//     res_valid, res_match, res_index[4:0], res_err, res_job[3:0]
// Modports: master = host side, slave = feeder side.
// ----------------------------------------------------------------------------
interface sme_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_kind;
  logic       in_last;

  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_err;
  logic [3:0] res_job;

  modport master (
    output in_valid, in_data, in_kind, in_last,
    input  in_ready,
    input  res_valid, res_match, res_index, res_err, res_job
  );

  modport slave (
    input  in_valid, in_data, in_kind, in_last,
    output in_ready,
    output res_valid, res_match, res_index, res_err, res_job
  );
endinterface

// File: rtl/sme_feeder.sv
// ----------------------------------------------------------------------------
// sme_feeder
// Upstream framing stage for the string-matching engine. Collects one string
// and one pattern from the host, replays them to the engine as back-to-back
// bursts, waits for the engine's result strobe (or a timeout) and returns a
// tagged result to the host. One job in flight at a time.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   host       sme_feeder_if.slave : byte channel in, result channel out
//   chardata   byte to engine (registered)
//   isstring   chardata is a string char (registered)
//   ispattern  chardata is a pattern char (registered)
//   sme_valid  engine result strobe, only honoured while waiting
//   sme_match  engine match flag
//   sme_index  engine match index
// ----------------------------------------------------------------------------
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  sme_feeder_if.slave       host,
  output logic [7:0]        chardata,
  output logic              isstring,
  output logic              ispattern,
  input  logic              sme_valid,
  input  logic              sme_match,
  input  logic [4:0]        sme_index
);

  localparam int SCW = $clog2(STR_MAX + 1);  // string count width
  localparam int SIW = $clog2(STR_MAX);      // string address width
  localparam int PCW = $clog2(PAT_MAX + 1);  // pattern count width
  localparam int PIW = $clog2(PAT_MAX);      // pattern address width
  localparam int IW  = (SCW > PCW) ? SCW : PCW;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    COLLECT,
    SEND_STR,
    SEND_PAT,
    WAIT,
    REPORT
  } state_t;

  state_t state_q, state_d;

  logic [SCW-1:0] str_cnt_q, str_cnt_d;
  logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           err_q, err_d;
  logic           new_str_q, new_str_d;
  logic           pat_seen_q, pat_seen_d;
  logic [3:0]     job_q, job_d;

  logic           in_ready_q, in_ready_d;
  logic [7:0]     chardata_q, chardata_d;
  logic           isstring_q, isstring_d;
  logic           ispattern_q, ispattern_d;
  logic           res_valid_q, res_valid_d;
  logic           res_match_q, res_match_d;
  logic [4:0]     res_index_q, res_index_d;
  logic           res_err_q, res_err_d;
  logic [3:0]     res_job_q, res_job_d;

  logic           accept;
  logic           str_we;
  logic           pat_we;

  logic [7:0]     str_buf [STR_MAX];
  logic [7:0]     pat_buf [PAT_MAX];

  // Buffer storage: written at the current fill count, no reset needed.
  always_ff @(posedge clk) begin
    if (str_we) str_buf[str_cnt_q[SIW-1:0]] <= host.in_data;
    if (pat_we) pat_buf[pat_cnt_q[PIW-1:0]] <= host.in_data;
  end

  always_comb begin
    state_d     = state_q;
    str_cnt_d   = str_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    idx_d       = idx_q;
    timer_d     = '0;
    err_d       = err_q;
    new_str_d   = new_str_q;
    pat_seen_d  = pat_seen_q;
    job_d       = job_q;
    res_valid_d = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    res_err_d   = res_err_q;
    res_job_d   = res_job_q;
    str_we      = 1'b0;
    pat_we      = 1'b0;
    accept      = host.in_valid & in_ready_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (!host.in_kind) begin
            // String bytes once a pattern has started, or beyond capacity,
            // are dropped and poison the job.
            if (pat_seen_q || (str_cnt_q == SCW'(STR_MAX))) begin
              err_d = 1'b1;
            end else begin
              str_we    = 1'b1;
              str_cnt_d = str_cnt_q + SCW'(1);
              new_str_d = 1'b1;
            end
          end else begin
            if (pat_cnt_q == PCW'(PAT_MAX)) begin
              err_d = 1'b1;
            end else begin
              pat_we    = 1'b1;
              pat_cnt_d = pat_cnt_q + PCW'(1);
            end
            pat_seen_d = 1'b1;
            if (host.in_last) begin
              idx_d = '0;
              // Empty segments are skipped so the bursts stay gap-free.
              if (new_str_q)               state_d = SEND_STR;
              else if (pat_cnt_d != '0)    state_d = SEND_PAT;
              else                         state_d = WAIT;
            end
          end
        end
      end

      SEND_STR: begin
        if (IW'(str_cnt_q) <= idx_q + IW'(1)) begin
          idx_d   = '0;
          state_d = (pat_cnt_q != '0) ? SEND_PAT : WAIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      SEND_PAT: begin
        if (IW'(pat_cnt_q) <= idx_q + IW'(1)) begin
          idx_d   = '0;
          state_d = WAIT;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (sme_valid) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_match ? sme_index : 5'd0;
          res_err_d   = err_q;
          res_job_d   = job_q;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = REPORT;
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
          res_err_d   = 1'b1;
          res_job_d   = job_q;
        end
      end

      REPORT: begin
        state_d    = COLLECT;
        job_d      = job_q + 4'd1;
        pat_cnt_d  = '0;
        err_d      = 1'b0;
        new_str_d  = 1'b0;
        pat_seen_d = 1'b0;
        // The string bytes remain in the buffer so a pattern-only job can
        // tell the engine to reuse them.
        if (new_str_q) str_cnt_d = '0;
      end

      default: state_d = COLLECT;
    endcase
  end

  // Registered outputs are derived from the next state so the first engine
  // byte leaves on the edge right after the launching byte is taken.
  always_comb begin
    in_ready_d  = (state_d == COLLECT);
    isstring_d  = (state_d == SEND_STR);
    ispattern_d = (state_d == SEND_PAT);
    chardata_d  = 8'd0;
    if (state_d == SEND_STR) begin
      chardata_d = str_buf[idx_d[SIW-1:0]];
    end else if (state_d == SEND_PAT) begin
      // A one-byte pattern launched without a string is being written on
      // this very edge; forward it instead of reading the stale entry.
      if (pat_we && (idx_d == IW'(pat_cnt_q))) chardata_d = host.in_data;
      else                                     chardata_d = pat_buf[idx_d[PIW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      str_cnt_q   <= '0;
      pat_cnt_q   <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      new_str_q   <= 1'b0;
      pat_seen_q  <= 1'b0;
      job_q       <= 4'd0;
      in_ready_q  <= 1'b0;
      chardata_q  <= 8'd0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= 5'd0;
      res_err_q   <= 1'b0;
      res_job_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      str_cnt_q   <= str_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      new_str_q   <= new_str_d;
      pat_seen_q  <= pat_seen_d;
      job_q       <= job_d;
      in_ready_q  <= in_ready_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      res_valid_q <= res_valid_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      res_err_q   <= res_err_d;
      res_job_q   <= res_job_d;
    end
  end

  assign host.in_ready  = in_ready_q;
  assign host.res_valid = res_valid_q;
  assign host.res_match = res_match_q;
  assign host.res_index = res_index_q;
  assign host.res_err   = res_err_q;
  assign host.res_job   = res_job_q;
  assign chardata       = chardata_q;
  assign isstring       = isstring_q;
  assign ispattern      = ispattern_q;

endmodule

// File: tb/tb_sme_feeder.sv
// ----------------------------------------------------------------------------
// tb_sme_feeder
// Directed bench for sme_feeder: drives host bytes, models the engine's
// result strobe, records the engine-side bursts and compares everything
// against hand-computed expectations. One line is printed per job result.
// ----------------------------------------------------------------------------
module tb_sme_feeder;
  localparam int TIMEOUT = 1024;

  logic       clk;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       sme_match;
  logic [4:0] sme_index;

  sme_feeder_if hif();

  sme_feeder #(
    .STR_MAX (32),
    .PAT_MAX (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (hif),
    .chardata  (chardata),
    .isstring  (isstring),
    .ispattern (ispattern),
    .sme_valid (sme_valid),
    .sme_match (sme_match),
    .sme_index (sme_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int both_cnt = 0;
  int res_pulses = 0;
  int last_drive_cyc;

  // Engine-side trace: one entry per cycle with isstring or ispattern high.
  int         act_cyc  [$];
  bit         act_kind [$];
  logic [7:0] act_data [$];

  logic [7:0] exp_s [$];
  logic [7:0] exp_p [$];

  logic       r_match;
  logic [4:0] r_index;
  logic       r_err;
  logic [3:0] r_job;
  int         r_lat;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (isstring || ispattern) begin
      act_cyc.push_back(cyc);
      act_kind.push_back(ispattern);
      act_data.push_back(chardata);
    end
    if (isstring && ispattern) both_cnt <= both_cnt + 1;
    if (hif.res_valid) res_pulses <= res_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit kind, input bit last);
    int n;
    n = 0;
    while (!hif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_wait", hif.in_ready, 1);
    hif.in_valid   = 1'b1;
    hif.in_data    = d;
    hif.in_kind    = kind;
    hif.in_last    = last;
    last_drive_cyc = cyc;
    @(negedge clk);
    hif.in_valid = 1'b0;
    hif.in_last  = 1'b0;
  endtask

  task automatic send_text(input string s, input bit kind);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], kind, i == s.len() - 1);
  endtask

  task automatic set_exp(input string s, input string p);
    exp_s.delete();
    exp_p.delete();
    for (int i = 0; i < s.len(); i++) exp_s.push_back(s[i]);
    for (int i = 0; i < p.len(); i++) exp_p.push_back(p[i]);
  endtask

  // Wait for the bursts to end, then either pulse the engine result or let
  // the feeder time out, and capture the returned result.
  task automatic finish_job(input bit pulse, input bit m, input logic [4:0] idx);
    int n;
    int wait_cyc;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 200 && !(seen && !isstring && !ispattern)) begin
      if (isstring || ispattern) seen = 1;
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("burst_end", {31'd0, isstring | ispattern}, 0);
    wait_cyc = cyc;
    check("wait_chardata", chardata, 8'h00);
    if (pulse) begin
      sme_valid = 1'b1;
      sme_match = m;
      sme_index = idx;
      @(negedge clk);
      sme_valid = 1'b0;
      sme_match = 1'b0;
      sme_index = 5'd0;
      check("res_lat1", hif.res_valid, 1);
    end else begin
      n = 0;
      while (!hif.res_valid && n < TIMEOUT + 100) begin
        @(negedge clk);
        n++;
      end
      check("res_seen", hif.res_valid, 1);
    end
    r_lat   = cyc - wait_cyc;
    r_match = hif.res_match;
    r_index = hif.res_index;
    r_err   = hif.res_err;
    r_job   = hif.res_job;
    $display("job %0d: match=%0d index=%0d err=%0d lat=%0d", r_job, r_match, r_index, r_err, r_lat);
    @(negedge clk);
    check("res_pulse_1cyc", hif.res_valid, 0);
  endtask

  task automatic check_burst(input string tag, input int base, input int drive_cyc);
    int ns;
    int np;
    bit contig;
    bit order;
    ns = 0;
    np = 0;
    contig = 1;
    order = 1;
    for (int k = base; k < act_cyc.size(); k++) begin
      if (act_cyc[k] != act_cyc[base] + (k - base)) contig = 0;
      if (act_kind[k]) begin
        if (np < exp_p.size()) check({tag, "_pat"}, act_data[k], exp_p[np]);
        np++;
      end else begin
        if (np != 0) order = 0;
        if (ns < exp_s.size()) check({tag, "_str"}, act_data[k], exp_s[ns]);
        ns++;
      end
    end
    check({tag, "_nstr"}, ns, exp_s.size());
    check({tag, "_npat"}, np, exp_p.size());
    check({tag, "_contig"}, {31'd0, contig}, 1);
    check({tag, "_order"}, {31'd0, order}, 1);
    if (act_cyc.size() > base) check({tag, "_latency"}, act_cyc[base] - drive_cyc, 1);
    else check({tag, "_present"}, act_cyc.size(), base + 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cnt;
    int n;

    reset = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_data  = 8'h00;
    hif.in_kind  = 1'b0;
    hif.in_last  = 1'b0;
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", hif.in_ready, 0);
    check("rst_isstring", isstring, 0);
    check("rst_ispattern", ispattern, 0);
    check("rst_chardata", chardata, 0);
    check("rst_res_valid", hif.res_valid, 0);
    check("rst_res_job", hif.res_job, 0);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", hif.in_ready, 1);

    // Job 0: string "ab cd", pattern "cd"
    base = act_cyc.size();
    set_exp("ab cd", "cd");
    send_text("ab cd", 1'b0);
    send_text("cd", 1'b1);
    finish_job(1'b1, 1'b1, 5'd3);
    check_burst("j0", base, last_drive_cyc);
    check("j0_match", r_match, 1);
    check("j0_index", r_index, 3);
    check("j0_err", r_err, 0);
    check("j0_job", r_job, 0);

    // Job 1: pattern-only "^ab", engine reports no match with a stray index
    base = act_cyc.size();
    set_exp("", "^ab");
    send_text("^ab", 1'b1);
    finish_job(1'b1, 1'b0, 5'd5);
    check_burst("j1", base, last_drive_cyc);
    check("j1_match", r_match, 0);
    check("j1_index", r_index, 0);
    check("j1_err", r_err, 0);
    check("j1_job", r_job, 1);

    // Job 2: 34 string bytes overflow a 32-deep buffer
    base = act_cyc.size();
    exp_s.delete();
    exp_p.delete();
    for (int i = 0; i < 32; i++) exp_s.push_back(8'h40 + 8'(i));
    exp_p.push_back(8'h78);
    for (int i = 0; i < 34; i++) send_byte(8'h40 + 8'(i), 1'b0, i == 33);
    send_byte(8'h78, 1'b1, 1'b1);
    finish_job(1'b1, 1'b0, 5'd0);
    check_burst("j2", base, last_drive_cyc);
    check("j2_err", r_err, 1);
    check("j2_job", r_job, 2);

    // Job 3: string byte inside the pattern segment is dropped
    base = act_cyc.size();
    set_exp("", "ab");
    send_byte(8'h61, 1'b1, 1'b0);
    send_byte(8'h7A, 1'b0, 1'b0);
    send_byte(8'h62, 1'b1, 1'b1);
    finish_job(1'b1, 1'b1, 5'd7);
    check_burst("j3", base, last_drive_cyc);
    check("j3_match", r_match, 1);
    check("j3_index", r_index, 7);
    check("j3_err", r_err, 1);
    check("j3_job", r_job, 3);

    // Job 4: one-byte pattern, engine never answers
    base = act_cyc.size();
    set_exp("", "q");
    send_text("q", 1'b1);
    finish_job(1'b0, 1'b0, 5'd0);
    check_burst("j4", base, last_drive_cyc);
    check("j4_timeout_lat", r_lat, TIMEOUT);
    check("j4_match", r_match, 0);
    check("j4_index", r_index, 0);
    check("j4_err", r_err, 1);
    check("j4_job", r_job, 4);

    // Stray engine strobe while collecting
    sme_valid = 1'b1;
    sme_match = 1'b1;
    sme_index = 5'd9;
    @(negedge clk);
    sme_valid = 1'b0;
    sme_match = 1'b0;
    sme_index = 5'd0;
    repeat (5) @(negedge clk);
    check("stray_no_result", res_pulses, 5);

    // Job 5: reset while the fourth string byte is on the bus
    send_text("ab cd", 1'b0);
    send_text("cd", 1'b1);
    cnt = 0;
    n = 0;
    while (n < 50) begin
      if (isstring) begin
        if (cnt == 3) break;
        cnt++;
      end
      @(negedge clk);
      n++;
    end
    check("abort_byte3", chardata, 8'h63);
    reset = 1'b0;
    #1;
    check("abort_isstring", isstring, 0);
    check("abort_chardata", chardata, 0);
    check("abort_in_ready", hif.in_ready, 0);
    check("abort_res_job", hif.res_job, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_result", res_pulses, 5);

    // Post-reset job restarts numbering at 0
    base = act_cyc.size();
    set_exp("hi", "i$");
    send_text("hi", 1'b0);
    send_text("i$", 1'b1);
    finish_job(1'b1, 1'b1, 5'd1);
    check_burst("j6", base, last_drive_cyc);
    check("j6_match", r_match, 1);
    check("j6_index", r_index, 1);
    check("j6_err", r_err, 0);
    check("j6_job", r_job, 0);

    repeat (2) @(negedge clk);
    check("total_results", res_pulses, 6);
    check("str_pat_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
